sprite_palette_bank: RTL

- Parametrised, runtime-writable colour palette for sprite pixel lookup.
- Sits between the sprite ROM index output and the VGA colour mux.
- Holds NUM_BANKS banks of 2^INDEX_W entries, each entry being an RGB triple of width COLOR_W per channel.
- Adds features a fixed lookup lacks:
  - a registered pixel pipeline with valid;
  - frame-synchronous bank switching (e.g. player 1/player 2 recolour);
  - a transparency flag;
  - a damage-flash mode that forces opaque pixels to white.

---
 rtl/sprite_palette_pkg.sv | 35 +++
 rtl/palette_flash_fsm.sv | 72 +++++++
 rtl/sprite_palette_bank.sv | 130 +++++++++++++
 3 files changed

// File: rtl/sprite_palette_pkg.sv
// Shared types and the power-on colour table for the sprite palette bank.
package sprite_palette_pkg;

    localparam int PAL_COLOR_W = 4;
    localparam int DEFAULT_LEN = 16;

    typedef struct packed {
        logic [PAL_COLOR_W-1:0] r;
        logic [PAL_COLOR_W-1:0] g;
        logic [PAL_COLOR_W-1:0] b;
    } rgb_t;

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        ON_LO = 2'd1,
        ON_HI = 2'd2
    } flash_state_e;

    // Entry 0 is the magenta key colour; entry 3 is white, entry 4 the damage red.
    localparam logic [11:0] DEFAULT_PALETTE [DEFAULT_LEN] = '{
        12'hF0F, 12'h3D7, 12'h000, 12'hFFF,
        12'hE33, 12'h36C, 12'hFC2, 12'h8A4,
        12'h555, 12'hAAA, 12'h9E1, 12'h41B,
        12'hC7F, 12'h0B9, 12'hD80, 12'h222
    };

    function automatic rgb_t default_entry(input int idx);
        if (idx >= 0 && idx < DEFAULT_LEN) begin
            return rgb_t'(DEFAULT_PALETTE[idx[3:0]]);
        end else begin
            return rgb_t'(12'h000);
        end
    endfunction

endpackage

// File: rtl/palette_flash_fsm.sv
// Damage-flash sequencer: counts frame starts while enabled and alternates
// the flash phase every FLASH_FRAMES frames.
module palette_flash_fsm
    import sprite_palette_pkg::*;
#(
    parameter int FLASH_FRAMES = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic frame_start_i,
    input  logic flash_en_i,
    output logic flash_phase_o
);

    localparam int CNT_W = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FLASH_FRAMES - 1);

    flash_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             phase_q;

    // Next-state logic; the frame start coinciding with enable is not counted.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!flash_en_i) begin
            state_d = OFF;
            cnt_d   = {CNT_W{1'b0}};
        end else begin
            case (state_q)
                OFF: begin
                    state_d = ON_LO;
                    cnt_d   = {CNT_W{1'b0}};
                end
                ON_LO, ON_HI: begin
                    if (frame_start_i) begin
                        if (cnt_q == CNT_LAST) begin
                            cnt_d   = {CNT_W{1'b0}};
                            state_d = (state_q == ON_LO) ? ON_HI : ON_LO;
                        end else begin
                            cnt_d   = cnt_q + CNT_W'(1);
                            state_d = state_q;
                        end
                    end else begin
                        cnt_d   = cnt_q;
                        state_d = state_q;
                    end
                end
                default: begin
                    state_d = OFF;
                    cnt_d   = {CNT_W{1'b0}};
                end
            endcase
        end
    end

    // State, counter and registered phase output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= OFF;
            cnt_q   <= {CNT_W{1'b0}};
            phase_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            phase_q <= (state_d == ON_HI);
        end
    end

    assign flash_phase_o = phase_q;

endmodule

// File: rtl/sprite_palette_bank.sv
// Runtime-writable multi-bank sprite palette with a one-cycle lookup pipeline,
// frame-synchronous bank switching, transparency and damage flash.
module sprite_palette_bank
    import sprite_palette_pkg::*;
#(
    parameter int INDEX_W           = 4,
    parameter int NUM_BANKS         = 2,
    parameter int COLOR_W           = 4,
    parameter int FLASH_FRAMES      = 8,
    parameter int TRANSPARENT_INDEX = 0,
    localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pix_valid_i,
    input  logic [INDEX_W-1:0]   index_i,
    input  logic                 frame_start_i,
    input  logic [BANK_W-1:0]    bank_sel_i,
    input  logic                 flash_en_i,
    input  logic                 wr_en_i,
    input  logic [BANK_W-1:0]    wr_bank_i,
    input  logic [INDEX_W-1:0]   wr_addr_i,
    input  logic [3*COLOR_W-1:0] wr_data_i,
    output logic                 pix_valid_o,
    output logic [COLOR_W-1:0]   red_o,
    output logic [COLOR_W-1:0]   green_o,
    output logic [COLOR_W-1:0]   blue_o,
    output logic                 opaque_o,
    output logic                 flash_phase_o,
    output logic [BANK_W-1:0]    active_bank_o
);

    localparam int DEPTH   = 1 << INDEX_W;
    localparam int ENTRY_W = 3 * COLOR_W;
    localparam logic [BANK_W:0]    NB_LIMIT   = (BANK_W + 1)'(NUM_BANKS);
    localparam logic [INDEX_W-1:0] TRANS_IDX  = INDEX_W'(TRANSPARENT_INDEX);

    logic [ENTRY_W-1:0] mem_q [NUM_BANKS][DEPTH];
    logic [BANK_W-1:0]  active_bank_q;
    logic               pix_valid_q;
    logic               opaque_q, opaque_d;
    logic [ENTRY_W-1:0] rgb_q, rgb_d;
    logic               wr_ok_s, sel_ok_s, flash_phase_s;
    logic [ENTRY_W-1:0] rd_entry_s;

    // The default table is only meaningful for the 4-bit-per-channel layout.
    function automatic logic [ENTRY_W-1:0] reset_entry(input int e);
        if (COLOR_W == PAL_COLOR_W) begin
            return ENTRY_W'(default_entry(e));
        end else begin
            return {ENTRY_W{1'b0}};
        end
    endfunction

    palette_flash_fsm #(
        .FLASH_FRAMES (FLASH_FRAMES)
    ) u_flash (
        .clk           (clk),
        .rst           (rst),
        .frame_start_i (frame_start_i),
        .flash_en_i    (flash_en_i),
        .flash_phase_o (flash_phase_s)
    );

    assign wr_ok_s    = ({1'b0, wr_bank_i}  < NB_LIMIT);
    assign sel_ok_s   = ({1'b0, bank_sel_i} < NB_LIMIT);
    assign rd_entry_s = mem_q[active_bank_q][index_i];

    // Palette storage; reads see the pre-edge contents, giving read-before-write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                for (int e = 0; e < DEPTH; e++) begin
                    mem_q[b][e] <= reset_entry(e);
                end
            end
        end else if (wr_en_i && wr_ok_s) begin
            mem_q[wr_bank_i][wr_addr_i] <= wr_data_i;
        end
    end

    // Active bank only moves on a frame start, so a frame never tears.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_bank_q <= {BANK_W{1'b0}};
        end else if (frame_start_i && sel_ok_s) begin
            active_bank_q <= bank_sel_i;
        end
    end

    // Colour selection for the next output pixel; idle cycles hold the last one.
    always_comb begin
        rgb_d    = rgb_q;
        opaque_d = opaque_q;
        if (pix_valid_i) begin
            if (index_i == TRANS_IDX) begin
                rgb_d    = {ENTRY_W{1'b0}};
                opaque_d = 1'b0;
            end else begin
                rgb_d    = flash_phase_s ? {ENTRY_W{1'b1}} : rd_entry_s;
                opaque_d = 1'b1;
            end
        end else begin
            rgb_d    = rgb_q;
            opaque_d = opaque_q;
        end
    end

    // Output pipeline register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_valid_q <= 1'b0;
            rgb_q       <= {ENTRY_W{1'b0}};
            opaque_q    <= 1'b0;
        end else begin
            pix_valid_q <= pix_valid_i;
            rgb_q       <= rgb_d;
            opaque_q    <= opaque_d;
        end
    end

    assign pix_valid_o   = pix_valid_q;
    assign red_o         = rgb_q[3*COLOR_W-1 -: COLOR_W];
    assign green_o       = rgb_q[2*COLOR_W-1 -: COLOR_W];
    assign blue_o        = rgb_q[COLOR_W-1   -: COLOR_W];
    assign opaque_o      = opaque_q;
    assign flash_phase_o = flash_phase_s;
    assign active_bank_o = active_bank_q;

endmodule
